// File: rtl/mesi_pkg.sv
// Shared types and constants for the MESI request master and its command queue.
package mesi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CPL   = 2'd3
    } mesi_state_e;

    localparam int RESP_DONE  = 0;
    localparam int RESP_ERR   = 1;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mesi_cmd_fifo.sv
// Command queue for the request master: power-of-two depth, storing {write, addr, wdata}.
module mesi_cmd_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // Full is judged on the registered count, so a pop never frees a slot for the same-cycle push.
    assign full   = (r_count == (PTR_W + 1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mesi_req_master.sv
// Queues cache commands and drives them one at a time onto the cache request channels,
// returning a completion (with error/timeout status) for each.
//
// state    | meaning
// ST_IDLE  | waiting for a queued command; pops the head when one is present
// ST_ISSUE | one cycle of awvalid+wvalid (write) or arvalid (read)
// ST_WAIT  | waiting for the matching response, bounded by TIMEOUT cycles
// ST_CPL   | completion presented until cpl_ready
module mesi_req_master
    import mesi_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic              cpl_write,
    output logic [DATA_W-1:0] cpl_rdata,
    output logic              cpl_err,
    output logic              cpl_timeout,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              awvalid,
    output logic              wvalid,
    output logic              arvalid,
    input  logic [1:0]        w_resp,
    input  logic [1:0]        r_resp,
    input  logic [DATA_W-1:0] rdata
);

    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mesi_state_e       r_state;
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_cpl_write;
    logic              r_cpl_err;
    logic              r_cpl_timeout;
    logic [DATA_W-1:0] r_cpl_rdata;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [CMD_W-1:0]  w_head;
    logic              w_head_write;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;
    logic [1:0]        w_resp_sel;
    logic              w_done;
    logic              w_busy;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;

    mesi_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({cmd_write, cmd_addr, cmd_wdata}),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    assign {w_head_write, w_head_addr, w_head_wdata} = w_head;

    // Only the response channel matching the command type is looked at.
    assign w_resp_sel = r_cmd_write ? w_resp : r_resp;
    assign w_done     = w_resp_sel[RESP_DONE];
    assign w_busy     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

    assign awvalid     = (r_state == ST_ISSUE) && r_cmd_write;
    assign wvalid      = (r_state == ST_ISSUE) && r_cmd_write;
    assign arvalid     = (r_state == ST_ISSUE) && !r_cmd_write;
    assign data_addr   = w_busy ? r_cmd_addr  : '0;
    assign wdata       = w_busy ? r_cmd_wdata : '0;
    assign cpl_valid   = (r_state == ST_CPL);
    assign cpl_write   = r_cpl_write;
    assign cpl_err     = r_cpl_err;
    assign cpl_timeout = r_cpl_timeout;
    assign cpl_rdata   = r_cpl_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cmd_write   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_wdata   <= '0;
            r_tmo_cnt     <= '0;
            r_cpl_write   <= 1'b0;
            r_cpl_err     <= 1'b0;
            r_cpl_timeout <= 1'b0;
            r_cpl_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cmd_write <= w_head_write;
                        r_cmd_addr  <= w_head_addr;
                        r_cmd_wdata <= w_head_wdata;
                        r_tmo_cnt   <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    // A response in the final WAIT cycle takes priority over the timeout.
                    if (w_done) begin
                        r_cpl_write   <= r_cmd_write;
                        r_cpl_err     <= w_resp_sel[RESP_ERR];
                        r_cpl_timeout <= 1'b0;
                        r_cpl_rdata   <= r_cmd_write ? '0 : rdata;
                        r_state       <= ST_CPL;
                    end else if (r_state == ST_ISSUE) begin
                        r_state <= ST_WAIT;
                    end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_cpl_write   <= r_cmd_write;
                        r_cpl_err     <= 1'b1;
                        r_cpl_timeout <= 1'b1;
                        r_cpl_rdata   <= '0;
                        r_state       <= ST_CPL;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_CPL: begin
                    if (cpl_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_req_master.sv
// Directed bench for mesi_req_master: expected completions are queued at command time
// and compared against each cpl_valid in order.
module tb_mesi_req_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cpl_valid;
    logic        cpl_ready;
    logic        cpl_write;
    logic [31:0] cpl_rdata;
    logic        cpl_err;
    logic        cpl_timeout;
    logic [19:0] data_addr;
    logic [31:0] wdata;
    logic        awvalid;
    logic        wvalid;
    logic        arvalid;
    logic [1:0]  w_resp;
    logic [1:0]  r_resp;
    logic [31:0] rdata;

    typedef struct {
        logic        w;
        logic        err;
        logic        tmo;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    mesi_req_master dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cpl_valid   (cpl_valid),
        .cpl_ready   (cpl_ready),
        .cpl_write   (cpl_write),
        .cpl_rdata   (cpl_rdata),
        .cpl_err     (cpl_err),
        .cpl_timeout (cpl_timeout),
        .data_addr   (data_addr),
        .wdata       (wdata),
        .awvalid     (awvalid),
        .wvalid      (wvalid),
        .arvalid     (arvalid),
        .w_resp      (w_resp),
        .r_resp      (r_resp),
        .rdata       (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic w, input logic err, input logic tmo, input logic [31:0] d);
        exp_t e;
        e.w = w; e.err = err; e.tmo = tmo; e.rdata = d;
        sb_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_awvalid"},   awvalid,     1'b0);
        chk({tag, "_wvalid"},    wvalid,      1'b0);
        chk({tag, "_arvalid"},   arvalid,     1'b0);
        chk({tag, "_cpl_valid"}, cpl_valid,   1'b0);
        chk({tag, "_cpl_err"},   cpl_err,     1'b0);
        chk({tag, "_cpl_tmo"},   cpl_timeout, 1'b0);
        chk({tag, "_cpl_write"}, cpl_write,   1'b0);
        chk({tag, "_data_addr"}, data_addr,   20'h0);
        chk({tag, "_wdata"},     wdata,       32'h0);
        chk({tag, "_cpl_rdata"}, cpl_rdata,   32'h0);
        chk({tag, "_cmd_ready"}, cmd_ready,   1'b1);
    endtask

    task automatic send_cmd(input logic w, input logic [19:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 20) begin step(); n++; end
        chk("send_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input logic w, input int exp_acc, output int acc);
        acc = 0;
        for (int j = 0; j < n; j++) begin
            cmd_valid = 1'b1; cmd_write = w;
            cmd_addr  = 20'h81000 + 20'(acc * 16);
            cmd_wdata = 32'h100 + 32'(acc);
            chk("feed_ready", cmd_ready, j < exp_acc);
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        while (!(awvalid || arvalid) && n < 20) begin step(); n++; end
        chk("issue_seen", awvalid || arvalid, 1'b1);
    endtask

    task automatic wait_cpl(input int max, input string tag);
        exp_t e;
        int   n = 0;
        while (!cpl_valid && n < max) begin step(); n++; end
        chk({tag, "_seen"}, cpl_valid, 1'b1);
        if (cpl_valid) begin
            chk({tag, "_sb_nonempty"}, sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({tag, "_write"}, cpl_write,   e.w);
                chk({tag, "_err"},   cpl_err,     e.err);
                chk({tag, "_tmo"},   cpl_timeout, e.tmo);
                chk({tag, "_rdata"}, cpl_rdata,   e.rdata);
                step();
                chk({tag, "_hold_valid"}, cpl_valid, 1'b1);
                chk({tag, "_hold_rdata"}, cpl_rdata, e.rdata);
            end
            cpl_ready = 1'b1;
            step();
            cpl_ready = 1'b0;
            chk({tag, "_consumed"}, cpl_valid, 1'b0);
        end
    endtask

    initial begin
        int n;
        int acc;
        int cnt_cpl;
        int cnt_req;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cpl_ready = 1'b0; w_resp = 2'b00; r_resp = 2'b00; rdata = '0;
        #2;
        check_reset_vals("rst0");
        repeat (2) step();
        rst = 1'b0;
        step();

        // write, w_resp two cycles after awvalid
        send_cmd(1'b1, 20'h81000, 32'h1234_5678);
        push_exp(1'b1, 1'b0, 1'b0, 32'h0);
        wait_issue(n);
        chk("wr_issue_lat", n, 1);
        chk("wr_awvalid", awvalid, 1'b1);
        chk("wr_wvalid", wvalid, 1'b1);
        chk("wr_arvalid", arvalid, 1'b0);
        chk("wr_addr", data_addr, 20'h81000);
        chk("wr_wdata", wdata, 32'h1234_5678);
        step();
        chk("wr_aw_single", awvalid, 1'b0);
        chk("wr_w_single", wvalid, 1'b0);
        chk("wr_addr_hold", data_addr, 20'h81000);
        step();
        w_resp = 2'b01;
        step();
        w_resp = 2'b00;
        wait_cpl(0, "wr");
        chk("idle_addr_zero", data_addr, 20'h0);

        // read with stray w_resp pulse, minimum latency
        send_cmd(1'b0, 20'h81400, 32'h0);
        push_exp(1'b0, 1'b0, 1'b0, 32'hBEEF_DEAD);
        step();
        chk("rd_arvalid", arvalid, 1'b1);
        chk("rd_awvalid", awvalid, 1'b0);
        chk("rd_addr", data_addr, 20'h81400);
        w_resp = 2'b01;
        step();
        w_resp = 2'b00; r_resp = 2'b01; rdata = 32'hBEEF_DEAD;
        step();
        r_resp = 2'b00; rdata = 32'h0;
        chk("rd_latency3", cpl_valid, 1'b1);
        wait_cpl(0, "rd");

        // write error response
        send_cmd(1'b1, 20'h81800, 32'hCAFE_0001);
        push_exp(1'b1, 1'b1, 1'b0, 32'h0);
        wait_issue(n);
        step();
        w_resp = 2'b11; r_resp = 2'b01; rdata = 32'h7777_7777;
        step();
        w_resp = 2'b00; r_resp = 2'b00; rdata = 32'h0;
        wait_cpl(0, "wr_err");

        // read with no response: 1 ISSUE + 64 WAIT cycles
        rdata = 32'hFFFF_FFFF;
        send_cmd(1'b0, 20'h81C00, 32'h0);
        push_exp(1'b0, 1'b1, 1'b1, 32'h0);
        wait_issue(n);
        n = 0;
        while (!cpl_valid && n < 200) begin step(); n++; end
        chk("tmo_cycles", n, 65);
        wait_cpl(0, "tmo");
        rdata = 32'h0;

        // response in the last WAIT cycle beats the timeout
        send_cmd(1'b0, 20'h81C40, 32'h0);
        push_exp(1'b0, 1'b0, 1'b0, 32'h5A5A_0001);
        wait_issue(n);
        repeat (64) step();
        r_resp = 2'b01; rdata = 32'h5A5A_0001;
        step();
        r_resp = 2'b00; rdata = 32'h0;
        wait_cpl(0, "tmo_edge");

        // six back-to-back reads: five accepted, in-order completions
        feed(6, 1'b0, 5, acc);
        chk("b2b_accepted", acc, 5);
        chk("b2b_full", cmd_ready, 1'b0);
        for (int i = 0; i < 5; i++) push_exp(1'b0, 1'b0, 1'b0, 32'hD000_0000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_issue(n);
                step();
            end
            chk("b2b_order_addr", data_addr, 20'h81000 + 20'(i * 16));
            r_resp = 2'b01; rdata = 32'hD000_0000 + 32'(i);
            step();
            r_resp = 2'b00; rdata = 32'h0;
            wait_cpl(0, "b2b");
        end

        // reset in WAIT with three commands queued
        feed(4, 1'b1, 4, acc);
        chk("rst_pre_addr", data_addr, 20'h81000);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        step();
        step();
        rst = 1'b0;
        cnt_cpl = 0;
        cnt_req = 0;
        for (int i = 0; i < 100; i++) begin
            w_resp = (i < 3) ? 2'b01 : 2'b00;
            r_resp = (i < 3) ? 2'b01 : 2'b00;
            step();
            if (cpl_valid) cnt_cpl++;
            if (awvalid || wvalid || arvalid) cnt_req++;
        end
        chk("rst_no_cpl", cnt_cpl, 0);
        chk("rst_no_issue", cnt_req, 0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
